alu_arbiter: RTL and testbench

Shares one combinational RV32 integer ALU between `N_REQ` requesters, for example the execute stage and a branch/address-generation helper. Each cycle it grants at most one request by round-robin and evaluates it in a single shared `alu` instance. The result is captured in that requester's private response register, which holds it until the requester accepts it through a valid/ready handshake. The block sits in the execute cluster, between issue logic and writeback.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 38 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 82 ++++++++
 tb/tb_alu_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared RV32 integer ALU definitions: funct3 encodings and the request payload.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FNC_ADD_SUB = 3'b000;
  localparam logic [2:0] FNC_SLL     = 3'b001;
  localparam logic [2:0] FNC_SLT     = 3'b010;
  localparam logic [2:0] FNC_SLTU    = 3'b011;
  localparam logic [2:0] FNC_XOR     = 3'b100;
  localparam logic [2:0] FNC_SRL_SRA = 3'b101;
  localparam logic [2:0] FNC_OR      = 3'b110;
  localparam logic [2:0] FNC_AND     = 3'b111;

  typedef struct packed {
    logic [2:0]      fnc3;
    logic            fnc1;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU (register-register ops, funct3 + funct7[5]).
module alu
  import alu_pkg::*;
(
  input  logic [2:0]      fnc3,
  input  logic            fnc1,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd
);

  logic [4:0]             shamt;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic [XLEN-1:0]        sra;

  assign shamt = rs2[4:0];
  assign rs1_s = rs1;
  assign rs2_s = rs2;
  // Kept on its own so the arithmetic shift is not demoted by unsigned context.
  assign sra   = rs1_s >>> shamt;

  always_comb begin
    rd = '0;
    case (fnc3)
      FNC_ADD_SUB: rd = fnc1 ? (rs1 - rs2) : (rs1 + rs2);
      FNC_SLL:     rd = rs1 << shamt;
      FNC_SLT:     rd = {{(XLEN-1){1'b0}}, (rs1_s < rs2_s)};
      FNC_SLTU:    rd = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      FNC_XOR:     rd = rs1 ^ rs2;
      FNC_SRL_SRA: rd = fnc1 ? sra : (rs1 >> shamt);
      FNC_OR:      rd = rs1 | rs2;
      FNC_AND:     rd = rs1 & rs2;
      default:     rd = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic            grant_any,
  output logic [ID_W-1:0] next_ptr
);

  localparam int unsigned SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    next_ptr  = ptr;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = ID_W'(sum);
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        next_ptr   = (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters; each result waits in a per-requester
// response register until consumed through rsp_valid/rsp_ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][2:0]       req_fnc3,
  input  logic [N_REQ-1:0]            req_fnc1,
  input  logic [N_REQ-1:0][XLEN-1:0]  req_rs1,
  input  logic [N_REQ-1:0][XLEN-1:0]  req_rs2,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [N_REQ-1:0][XLEN-1:0]  rsp_rd,
  output logic                        busy
);

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] valid_next;
  logic             grant_any;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_ptr;
  alu_req_t         sel;
  logic [XLEN-1:0]  alu_rd;

  // A slot can take a new result if empty or being drained this cycle.
  assign eligible  = rst ? '0 : (req_valid & (~rsp_valid | rsp_ready));
  assign req_ready = grant;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_any (grant_any),
    .next_ptr  (next_ptr)
  );

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.fnc3 = req_fnc3[i];
        sel.fnc1 = req_fnc1[i];
        sel.rs1  = req_rs1[i];
        sel.rs2  = req_rs2[i];
      end
    end
  end

  alu u_alu (
    .fnc3 (sel.fnc3),
    .fnc1 (sel.fnc1),
    .rs1  (sel.rs1),
    .rs2  (sel.rs2),
    .rd   (alu_rd)
  );

  assign valid_next = grant | (rsp_valid & ~rsp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rd    <= '0;
      rr_ptr    <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= valid_next;
      busy      <= |valid_next;
      if (grant_any) rr_ptr <= next_ptr;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant[i]) rsp_rd[i] <= alu_rd;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then randomized traffic, all
// checked against a cycle-level reference model of grants and response slots.
module tb_alu_arbiter;
  localparam int unsigned NR = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][2:0]     req_fnc3;
  logic [NR-1:0]          req_fnc1;
  logic [NR-1:0][31:0]    req_rs1;
  logic [NR-1:0][31:0]    req_rs2;
  logic [NR-1:0]          rsp_valid;
  logic [NR-1:0]          rsp_ready;
  logic [NR-1:0][31:0]    rsp_rd;
  logic                   busy;

  alu_arbiter #(.N_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fnc3  (req_fnc3),
    .req_fnc1  (req_fnc1),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: result held per slot, occupancy, priority index.
  logic [31:0] m_rd [NR];
  bit          m_valid [NR];
  int          m_ptr;
  bit          pending [NR];

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic f1,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh = 32'(b[4:0]);
    logic [31:0] r;
    case (f3)
      3'd0: return f1 ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        r = a;
        for (int k = 0; k < int'(sh); k++) r = {f1 & a[31], r[31:1]};
        return r;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_grant();
    if (rst) return -1;
    for (int k = 0; k < int'(NR); k++) begin
      int i = (m_ptr + k) % int'(NR);
      if (req_valid[i] && (!m_valid[i] || rsp_ready[i])) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) begin
      m_rd[i] = '0; m_valid[i] = 1'b0; pending[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic check_outputs();
    bit any = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      check($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(m_valid[i]));
      check($sformatf("rsp_rd%0d", i), rsp_rd[i], m_rd[i]);
      any |= m_valid[i];
    end
    check("busy", 32'(busy), 32'(any));
  endtask

  // One clock: check the combinational grant, then the registered outcome.
  task automatic step();
    int g;
    logic [31:0] res = '0;
    #1;
    g = ref_grant();
    check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) res = ref_alu(req_fnc3[g], req_fnc1[g], req_rs1[g], req_rs2[g]);
    for (int i = 0; i < int'(NR); i++) pending[i] = req_valid[i] && (g != i);
    @(posedge clk); #1;
    for (int i = 0; i < int'(NR); i++) begin
      if (i == g) begin m_rd[i] = res; m_valid[i] = 1'b1; end
      else if (rsp_ready[i]) m_valid[i] = 1'b0;
    end
    if (g >= 0) m_ptr = (g + 1) % int'(NR);
    check_outputs();
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] f3, input logic f1,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v; req_fnc3[i] = f3; req_fnc1[i] = f1; req_rs1[i] = a; req_rs2[i] = b;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_fnc3 = '0; req_fnc1 = '0; req_rs1 = '0; req_rs2 = '0;
    rsp_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check_outputs();
    req_valid = '0;
    rst = 1'b0;

    // ADD 5+7 from requester 0
    set_req(0, 1'b1, 3'd0, 1'b0, 32'd5, 32'd7);
    step();
    check("add_result", rsp_rd[0], 32'd12);

    // Both requesting with draining responses: grants alternate
    rsp_ready = '1;
    set_req(0, 1'b1, 3'd0, 1'b1, 32'd3, 32'd5);
    set_req(1, 1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4);
    repeat (4) step();
    check("sub_result", rsp_rd[0], 32'hFFFF_FFFE);
    check("sra_result", rsp_rd[1], 32'hF800_0000);

    // Requester 1 never drains: it stalls, requester 0 keeps the ALU
    rsp_ready = 2'b01;
    repeat (4) step();
    check("stalled_slot1", 32'(rsp_valid[1]), 32'd1);

    // Drain and refill slot 0 in the same cycle
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step();
    check("slt_result", rsp_rd[0], 32'd1);
    set_req(0, 1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step();
    check("sltu_result", rsp_rd[0], 32'd0);
    set_req(0, 1'b1, 3'd1, 1'b0, 32'd1, 32'h21);
    step();
    check("sll_result", rsp_rd[0], 32'd2);

    // Fill both slots, then reset mid-operation
    rsp_ready = '0;
    set_req(0, 1'b1, 3'd4, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A);
    set_req(1, 1'b1, 3'd6, 1'b0, 32'h0F00_0000, 32'h0000_00F0);
    repeat (2) step();
    check("both_full", 32'(rsp_valid), 32'd3);
    pulse_reset();
    set_req(0, 1'b1, 3'd0, 1'b0, 32'd1, 32'd2);
    set_req(1, 1'b1, 3'd0, 1'b0, 32'd3, 32'd4);
    #1;
    check("post_reset_grant", 32'(req_ready), 32'd1);
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(199) == 0) pulse_reset();
      for (int i = 0; i < int'(NR); i++) begin
        if (!(pending[i] && $urandom_range(9) != 0)) begin
          req_valid[i] = ($urandom_range(3) != 0);
          req_fnc3[i]  = 3'($urandom);
          req_fnc1[i]  = 1'($urandom);
          case ($urandom_range(3))
            0:       req_rs1[i] = 32'h8000_0000 | 32'($urandom_range(3));
            1:       req_rs1[i] = 32'hFFFF_FFFF;
            default: req_rs1[i] = $urandom;
          endcase
          req_rs2[i] = ($urandom_range(1) != 0) ? 32'($urandom_range(40)) : $urandom;
        end
        rsp_ready[i] = ($urandom_range(2) != 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
